sum64_operand_loader: RTL
=========================

// Module: sum64_operand_loader
// PURPOSE
//  Upstream operand stage for the 64-bit adder (ports a, b, cin). Assembles two
//  OP_W-bit operands from a narrow WORD_W-bit stream, holds them stable together
//  with cin, and releases them with a valid/ready handshake to the adder-side consumer.
//  Lets a narrow bus drive the wide combinational adder with no glue logic.
// PARAMETERS
//  WORD_W  16  input word width; must divide OP_W exactly
//  OP_W    64  operand width; NW = OP_W/WORD_W words per operand
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-high
//  in_valid   in   1       in_data/in_cin valid this cycle
//  in_ready   out  1       loader accepts a word this cycle
//  in_data    in   WORD_W  operand word, least-significant word first
//  in_cin     in   1       carry-in; sampled only with the last word of b
//  a          out  OP_W    assembled operand A, to the adder's a
//  b          out  OP_W    assembled operand B, to the adder's b
//  cin        out  1       carry-in, to the adder's cin
//  out_valid  out  1       a/b/cin are complete and stable
//  out_ready  in   1       consumer has taken a/b/cin
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is synchronous, active-high.
//  - FSM states: LOAD_A -> LOAD_B -> PRESENT -> LOAD_A. A word counter wcnt
//    (width clog2(NW)) selects the slice being written.
//  - Word accept: a word is accepted when in_valid && in_ready. It is written to
//    slice [wcnt*WORD_W +: WORD_W] of a (LOAD_A) or b (LOAD_B), then wcnt increments.
//  - Transitions: LOAD_A moves to LOAD_B when word NW-1 of a is accepted. LOAD_B
//    moves to PRESENT when word NW-1 of b is accepted. wcnt wraps to 0 on each
//    state change.
//  - Carry-in: cin <= in_cin on the same accept as the last b word. in_cin is
//    ignored on every other word.
//  - Ready: in_ready = 1 in LOAD_A and LOAD_B, 0 in PRESENT. There is no
//    combinational path from out_ready to in_ready.
//  - Valid: out_valid = 1 only in PRESENT. It rises the cycle after the final b
//    word is accepted. Latency is 2*NW accepted words + 1 cycle.
//  - Hold: in PRESENT, a, b and cin hold constant until out_valid && out_ready.
//    On that edge the FSM goes to LOAD_A and in_ready = 1 on the next cycle.
//  - Register retention: a, b and cin keep their old values while reloading.
//    Upper slices are stale until overwritten; consumers qualify with out_valid.
//  - in_valid low: no state change (bubbles allowed anywhere, any length).
//  - out_ready high outside PRESENT: ignored.
//  - Reset: state=LOAD_A, wcnt=0, a=0, b=0, cin=0, out_valid=0, in_ready=1 on the
//    cycle after reset. Reset mid-load or in PRESENT discards the partial or
//    presented operands and the word being offered in that cycle. Reset wins over
//    any simultaneous handshake.
// CONFIGURATION
//  SUM64_LOADER_PARITY_EN (defined):
//  - Extra ports: in_par (in, 1, even parity of in_data) and par_err (out, 1, sticky).
//  - par_err sets on any accepted word where ^{in_data,in_par} != 0. It clears
//    only on reset or on the out_valid && out_ready handshake.
//  - Data flow and timing are unchanged; an error does not block the transfer.
//  SUM64_LOADER_PARITY_EN (undefined): in_par/par_err are absent; no parity logic.
// TESTING
//  1. Load a=64'hAAAA_AAAA_AAAA_AAAA (words 16'hAAAA x4), b=64'h5555_5555_5555_5555,
//     in_cin=1 with the last b word -> out_valid=1 next cycle with those values,
//     cin=1; the adder gives s=0, cout=1.
//  2. Words 1,2,3,4 then 5,6,7,8 -> a=64'h0004_0003_0002_0001,
//     b=64'h0008_0007_0006_0005 (LSW-first ordering).
//  3. Hold out_ready=0 for 10 cycles in PRESENT -> a, b and cin stay constant,
//     in_ready=0, and in_valid pulses are ignored. out_ready=1 -> LOAD_A next cycle.
//  4. in_valid toggled 1,0,1,0 during LOAD_A -> only asserted cycles advance wcnt;
//     result matches gap-free loading.
//  5. reset=1 after 5 accepted words -> state=LOAD_A, a=b=0, out_valid=0.
//     A fresh 8-word load completes correctly.
//  6. PARITY_EN: word 3 of a sent with wrong in_par -> par_err=1 from the next cycle
//     through PRESENT; clears on the handshake.

Source files
------------

// File: rtl/sum64_operand_loader.sv
// ============================================================================
// Module      : sum64_operand_loader
// Description : Assembles two OP_W-bit adder operands plus carry-in from a
//               narrow WORD_W-bit stream and presents them with valid/ready.
//               Optional even-parity checking: define SUM64_LOADER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sum64_operand_loader #(
   parameter int WORD_W = 16,
   parameter int OP_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_cin,
`ifdef SUM64_LOADER_PARITY_EN
   input  logic              in_par,
   output logic              par_err,
`endif
   output logic [OP_W-1:0]   a,
   output logic [OP_W-1:0]   b,
   output logic              cin,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int c_NW = OP_W / WORD_W;
   localparam int c_CW = (c_NW > 1) ? $clog2(c_NW) : 1;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(c_NW - 1);

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [c_CW-1:0]   r_wcnt;
   logic [OP_W-1:0]   r_a;
   logic [OP_W-1:0]   r_b;
   logic              r_cin;
   logic              w_accept;
   logic              w_last;
   logic              w_ready;
   logic              w_present;

   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_present   = 1'b0;
      w_last      = (r_wcnt == c_LAST);
      case (r_state)
         LOAD_A: begin
            w_ready = 1'b1;
            if (in_valid && w_last) w_state_nxt = LOAD_B;
         end
         LOAD_B: begin
            w_ready = 1'b1;
            if (in_valid && w_last) w_state_nxt = PRESENT;
         end
         PRESENT: begin
            w_present = 1'b1;
            if (out_ready) w_state_nxt = LOAD_A;
         end
         default: w_state_nxt = LOAD_A;
      endcase
      w_accept = in_valid && w_ready;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LOAD_A;
         r_wcnt  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_wcnt <= w_last ? '0 : r_wcnt + 1'b1;
            if (r_state == LOAD_A) begin
               r_a[r_wcnt*WORD_W +: WORD_W] <= in_data;
            end else begin
               r_b[r_wcnt*WORD_W +: WORD_W] <= in_data;
               // Carry-in travels with the final b word only.
               if (w_last) r_cin <= in_cin;
            end
         end
      end
   end

`ifdef SUM64_LOADER_PARITY_EN
   logic r_par_err;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_par_err <= 1'b0;
      end else if (w_present && out_ready) begin
         r_par_err <= 1'b0;
      end else if (w_accept && (^{in_data, in_par})) begin
         r_par_err <= 1'b1;
      end
   end

   assign par_err = r_par_err;
`endif

   assign in_ready  = w_ready;
   assign out_valid = w_present;
   assign a         = r_a;
   assign b         = r_b;
   assign cin       = r_cin;

endmodule

`default_nettype wire
